// File: rtl/bcd_timekeeper.sv
// 24-hour BCD time-of-day counter with a 1 Hz prescaler, a validated valid/ready
// time load, and single-field adjust pulses. It drives the six TM1638 digit nibbles.
module bcd_timekeeper #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk_50M,
  input  logic        rs,
  input  logic        run,
  input  logic [23:0] set_time,
  input  logic        set_valid,
  output logic        set_ready,
  output logic        set_done,
  output logic        set_err,
  input  logic        adj_inc,
  input  logic [1:0]  adj_field,
  output logic [3:0]  P1,
  output logic [3:0]  P2,
  output logic [3:0]  P3,
  output logic [3:0]  P4,
  output logic [3:0]  P5,
  output logic [3:0]  P6,
  output logic        tick_1hz,
  output logic        colon_on
);

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   PRE_HALF = PW'(TICK_DIV / 2);

  typedef enum logic {S_IDLE, S_CHECK} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [23:0]    r_time;
  logic [23:0]    r_cap;
  logic [PW-1:0]  r_pre;
  logic           r_colon;
  logic           r_tick;
  logic           r_done;
  logic           r_err;

  logic           w_ready;
  logic           w_cap_en;
  logic           w_apply;
  logic           w_reject;
  logic           w_tick;
  logic           w_adj;
  logic [23:0]    w_time_nxt;
  logic [PW-1:0]  w_pre_nxt;

  // Two BCD digits counting 00..59.
  function automatic logic [7:0] f_inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {((v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1), 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] f_inc_hour(input logic [7:0] h);
    logic [7:0] r;
    if (h == 8'h23) begin
      r = 8'h00;
    end else if (h[3:0] == 4'd9) begin
      r = {h[7:4] + 4'd1, 4'd0};
    end else begin
      r = {h[7:4], h[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Full one-second cascade S -> M -> H in a single cycle.
  function automatic logic [23:0] f_tick(input logic [23:0] t);
    logic [23:0] r;
    r       = t;
    r[7:0]  = f_inc60(t[7:0]);
    if (t[7:0] == 8'h59) begin
      r[15:8] = f_inc60(t[15:8]);
      if (t[15:8] == 8'h59) begin
        r[23:16] = f_inc_hour(t[23:16]);
      end
    end
    return r;
  endfunction

  function automatic logic f_valid(input logic [23:0] t);
    logic ok;
    ok = (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) &&
         (t[11:8] <= 4'd9) && (t[15:12] <= 4'd5) &&
         (t[23:20] <= 4'd2) && (t[19:16] <= 4'd9) &&
         ((t[23:20] < 4'd2) || (t[19:16] <= 4'd3));
    return ok;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_cap_en    = 1'b0;
    w_apply     = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (set_valid) begin
          w_cap_en    = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        if (f_valid(r_cap)) begin
          w_apply = 1'b1;
        end else begin
          w_reject = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A valid load overrides everything; otherwise adjust wins over the tick increment.
  always_comb begin
    w_time_nxt = r_time;
    w_pre_nxt  = r_pre;
    w_tick     = 1'b0;
    w_adj      = adj_inc && (r_state == S_IDLE) && (adj_field != 2'd3);
    if (w_apply) begin
      w_time_nxt = r_cap;
      w_pre_nxt  = '0;
    end else begin
      if (run) begin
        if (r_pre == PRE_MAX) begin
          w_pre_nxt = '0;
          w_tick    = 1'b1;
        end else begin
          w_pre_nxt = r_pre + PW'(1);
        end
      end
      if (w_adj) begin
        case (adj_field)
          2'd0:    w_time_nxt[7:0]   = 8'h00;
          2'd1:    w_time_nxt[15:8]  = f_inc60(r_time[15:8]);
          2'd2:    w_time_nxt[23:16] = f_inc_hour(r_time[23:16]);
          default: w_time_nxt        = r_time;
        endcase
      end else if (w_tick) begin
        w_time_nxt = f_tick(r_time);
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rs) begin
    if (!rs) begin
      r_state <= S_IDLE;
      r_time  <= 24'h000000;
      r_pre   <= '0;
      r_colon <= 1'b1;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_time  <= w_time_nxt;
      r_pre   <= w_pre_nxt;
      r_colon <= (w_pre_nxt < PRE_HALF);
      r_tick  <= w_tick;
      r_done  <= w_apply;
      r_err   <= w_reject;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (w_cap_en) begin
      r_cap <= set_time;
    end
  end

  assign set_ready = w_ready;
  assign set_done  = r_done;
  assign set_err   = r_err;
  assign tick_1hz  = r_tick;
  assign colon_on  = r_colon;
  assign P1        = r_time[23:20];
  assign P2        = r_time[19:16];
  assign P3        = r_time[15:12];
  assign P4        = r_time[11:8];
  assign P5        = r_time[7:4];
  assign P6        = r_time[3:0];

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed bench for bcd_timekeeper with TICK_DIV=10: counting, rollover, load
// validation, adjust, back-to-back loads, load/tick collision and async reset.
module tb_bcd_timekeeper;

  logic        clk_50M = 1'b0;
  logic        rs = 1'b1;
  logic        run = 1'b0;
  logic [23:0] set_time = 24'h0;
  logic        set_valid = 1'b0;
  logic        set_ready, set_done, set_err;
  logic        adj_inc = 1'b0;
  logic [1:0]  adj_field = 2'd3;
  logic [3:0]  P1, P2, P3, P4, P5, P6;
  logic        tick_1hz, colon_on;
  logic [23:0] p_all;

  int n_cmp = 0;
  int n_err = 0;

  assign p_all = {P1, P2, P3, P4, P5, P6};

  always #5 clk_50M = ~clk_50M;

  bcd_timekeeper #(.TICK_DIV(10)) dut (
    .clk_50M(clk_50M), .rs(rs), .run(run),
    .set_time(set_time), .set_valid(set_valid), .set_ready(set_ready),
    .set_done(set_done), .set_err(set_err),
    .adj_inc(adj_inc), .adj_field(adj_field),
    .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6),
    .tick_1hz(tick_1hz), .colon_on(colon_on)
  );

  // Drives one load from just after a negedge; returns observed handshake/result signals.
  task automatic do_load(input logic [23:0] v, output logic rdy0, output logic rdy1,
                         output logic dn0, output logic dn1, output logic er1);
    set_time  = v;
    set_valid = 1'b1;
    #1 rdy0 = set_ready;
    @(negedge clk_50M);
    set_valid = 1'b0;
    rdy1 = set_ready;
    dn0  = set_done;
    @(negedge clk_50M);
    dn1 = set_done;
    er1 = set_err;
  endtask

  task automatic test_reset();
    #2 rs = 1'b0;
    #1;
    n_cmp++; if (p_all !== 24'h0) begin n_err++; $display("FAIL reset_digits: got %h want 000000", p_all); end
    n_cmp++; if (set_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", set_ready); end
    n_cmp++; if (set_done !== 1'b0 || set_err !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got done=%b err=%b want 0/0", set_done, set_err); end
    n_cmp++; if (tick_1hz !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", tick_1hz); end
    n_cmp++; if (colon_on !== 1'b1) begin n_err++; $display("FAIL reset_colon: got %b want 1", colon_on); end
    @(negedge clk_50M);
    @(negedge clk_50M);
    rs = 1'b1;
  endtask

  task automatic test_tick();
    logic et, ec;
    run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_50M);
      et = (k % 10 == 0);
      ec = (k % 10 < 5);
      n_cmp++; if (tick_1hz !== et) begin n_err++; $display("FAIL tick_cycle%0d: got %b want %b", k, tick_1hz, et); end
      n_cmp++; if (colon_on !== ec) begin n_err++; $display("FAIL colon_cycle%0d: got %b want %b", k, colon_on, ec); end
      if (k == 10) begin
        n_cmp++; if (p_all !== 24'h000001) begin n_err++; $display("FAIL count_1s: got %h want 000001", p_all); end
      end
      if (k == 20) begin
        n_cmp++; if (p_all !== 24'h000002) begin n_err++; $display("FAIL count_2s: got %h want 000002", p_all); end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_rollover();
    logic r0, r1, d0, d1, e1;
    do_load(24'h235958, r0, r1, d0, d1, e1);
    n_cmp++; if ({r0, r1} !== 2'b10) begin n_err++; $display("FAIL load_ready: got %b%b want 10", r0, r1); end
    n_cmp++; if ({d0, d1, e1} !== 3'b010) begin n_err++; $display("FAIL load_done: got d0=%b d1=%b e=%b want 0/1/0", d0, d1, e1); end
    n_cmp++; if (p_all !== 24'h235958) begin n_err++; $display("FAIL load_value: got %h want 235958", p_all); end
    n_cmp++; if (colon_on !== 1'b1) begin n_err++; $display("FAIL load_colon: got %b want 1", colon_on); end
    run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_50M);
      if (k == 9) begin
        n_cmp++; if (tick_1hz !== 1'b0) begin n_err++; $display("FAIL early_tick: got %b want 0", tick_1hz); end
      end
      if (k == 10) begin
        n_cmp++; if (tick_1hz !== 1'b1 || p_all !== 24'h235959) begin n_err++; $display("FAIL roll_59: got tick=%b %h want 1 235959", tick_1hz, p_all); end
      end
      if (k == 20) begin
        n_cmp++; if (tick_1hz !== 1'b1 || p_all !== 24'h000000) begin n_err++; $display("FAIL roll_00: got tick=%b %h want 1 000000", tick_1hz, p_all); end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_invalid();
    logic [23:0] vals [4] = '{24'h126075, 24'h240000, 24'h1A0000, 24'h195959};
    logic        ok   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [23:0] expv;
    logic r0, r1, d0, d1, e1;
    expv = p_all;
    for (int i = 0; i < 4; i++) begin
      do_load(vals[i], r0, r1, d0, d1, e1);
      if (ok[i]) expv = vals[i];
      n_cmp++; if ({d1, e1} !== {ok[i], ~ok[i]}) begin n_err++; $display("FAIL validate_%h: got done=%b err=%b want ok=%b", vals[i], d1, e1, ok[i]); end
      n_cmp++; if (p_all !== expv) begin n_err++; $display("FAIL validate_digits_%h: got %h want %h", vals[i], p_all, expv); end
    end
  endtask

  task automatic test_adjust();
    logic r0, r1, d0, d1, e1;
    logic [1:0]  flds [5] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
    logic [23:0] expt [5] = '{24'h100030, 24'h004512, 24'h004500, 24'h004500, 24'h004600};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) do_load(24'h105930, r0, r1, d0, d1, e1);
      if (i == 1) do_load(24'h234512, r0, r1, d0, d1, e1);
      adj_inc   = 1'b1;
      adj_field = flds[i];
      @(negedge clk_50M);
      adj_inc = 1'b0;
      n_cmp++; if (p_all !== expt[i]) begin n_err++; $display("FAIL adjust_%0d: got %h want %h", i, p_all, expt[i]); end
    end
    // adjust during CHECK must be dropped
    set_time  = 24'h120000;
    set_valid = 1'b1;
    @(negedge clk_50M);
    set_valid = 1'b0;
    adj_inc   = 1'b1;
    adj_field = 2'd2;
    @(negedge clk_50M);
    adj_inc = 1'b0;
    n_cmp++; if (p_all !== 24'h120000 || set_done !== 1'b1) begin n_err++; $display("FAIL adjust_in_check: got %h done=%b want 120000 1", p_all, set_done); end
  endtask

  task automatic test_back_to_back();
    set_time  = 24'h010203;
    set_valid = 1'b1;
    #1;
    n_cmp++; if (set_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", set_ready); end
    @(negedge clk_50M);
    set_time = 24'h040506;
    n_cmp++; if (set_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready1: got %b want 0", set_ready); end
    @(negedge clk_50M);
    n_cmp++; if (set_ready !== 1'b1 || set_done !== 1'b1 || p_all !== 24'h010203) begin n_err++; $display("FAIL b2b_first: got rdy=%b done=%b %h want 1 1 010203", set_ready, set_done, p_all); end
    @(negedge clk_50M);
    set_valid = 1'b0;
    n_cmp++; if (set_ready !== 1'b0 || set_done !== 1'b0) begin n_err++; $display("FAIL b2b_check2: got rdy=%b done=%b want 0 0", set_ready, set_done); end
    @(negedge clk_50M);
    n_cmp++; if (set_ready !== 1'b1 || set_done !== 1'b1 || p_all !== 24'h040506) begin n_err++; $display("FAIL b2b_second: got rdy=%b done=%b %h want 1 1 040506", set_ready, set_done, p_all); end
  endtask

  task automatic test_load_in_tick();
    run = 1'b1;
    repeat (8) @(negedge clk_50M);
    set_time  = 24'h080000;
    set_valid = 1'b1;
    @(negedge clk_50M);
    set_valid = 1'b0;
    @(negedge clk_50M);
    n_cmp++; if (tick_1hz !== 1'b0 || set_done !== 1'b1 || p_all !== 24'h080000) begin n_err++; $display("FAIL load_tick_collide: got tick=%b done=%b %h want 0 1 080000", tick_1hz, set_done, p_all); end
    n_cmp++; if (colon_on !== 1'b1) begin n_err++; $display("FAIL load_tick_colon: got %b want 1", colon_on); end
    repeat (9) @(negedge clk_50M);
    n_cmp++; if (tick_1hz !== 1'b0) begin n_err++; $display("FAIL restart_early: got %b want 0", tick_1hz); end
    @(negedge clk_50M);
    n_cmp++; if (tick_1hz !== 1'b1 || p_all !== 24'h080001) begin n_err++; $display("FAIL restart_tick: got tick=%b %h want 1 080001", tick_1hz, p_all); end
    repeat (9) @(negedge clk_50M);
    adj_inc   = 1'b1;
    adj_field = 2'd1;
    @(negedge clk_50M);
    adj_inc = 1'b0;
    n_cmp++; if (tick_1hz !== 1'b1 || p_all !== 24'h080101) begin n_err++; $display("FAIL adj_tick_collide: got tick=%b %h want 1 080101", tick_1hz, p_all); end
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic r0, r1, d0, d1, e1;
    do_load(24'h235958, r0, r1, d0, d1, e1);
    run = 1'b1;
    repeat (5) @(negedge clk_50M);
    n_cmp++; if (colon_on !== 1'b0) begin n_err++; $display("FAIL mid_colon_pre: got %b want 0", colon_on); end
    #2 rs = 1'b0;
    #1;
    n_cmp++; if (p_all !== 24'h0 || colon_on !== 1'b1 || tick_1hz !== 1'b0) begin n_err++; $display("FAIL mid_count_reset: got %h colon=%b tick=%b want 000000 1 0", p_all, colon_on, tick_1hz); end
    @(negedge clk_50M);
    rs = 1'b1;
    set_time  = 24'h123456;
    set_valid = 1'b1;
    @(negedge clk_50M);
    set_valid = 1'b0;
    #2 rs = 1'b0;
    #1;
    n_cmp++; if (set_ready !== 1'b1 || set_done !== 1'b0 || set_err !== 1'b0 || p_all !== 24'h0) begin n_err++; $display("FAIL check_reset: got rdy=%b done=%b err=%b %h want 1 0 0 000000", set_ready, set_done, set_err, p_all); end
    @(negedge clk_50M);
    rs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_50M);
      n_cmp++; if (set_done !== 1'b0 || set_err !== 1'b0 || p_all !== 24'h0) begin n_err++; $display("FAIL post_reset_%0d: got done=%b err=%b %h want 0 0 000000", k, set_done, set_err, p_all); end
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_rollover();
    test_invalid();
    test_adjust();
    test_back_to_back();
    test_load_in_tick();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
